// File: rtl/store_commit_buffer.sv
// store_commit_buffer: in-order committed-store queue from ROB commit to the D-cache write port.
// Optional store-to-load forwarding is built when SB_FWD_EN is defined.
module store_commit_buffer #(
  parameter int SB_DEPTH = 4,
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        cmt_wr_en,
  input  logic [ADDR_W-1:0]           cmt_wr_addr,
  input  logic [DATA_W-1:0]           cmt_wr_data,
  output logic                        cmt_stall,
  output logic                        mem_req,
  output logic [ADDR_W-1:0]           mem_addr,
  output logic [DATA_W-1:0]           mem_data,
  input  logic                        mem_ready,
  input  logic [ADDR_W-1:0]           ld_addr,
  output logic                        ld_hit,
  output logic [DATA_W-1:0]           ld_data,
  output logic                        sb_empty,
  output logic [$clog2(SB_DEPTH):0]   sb_count
);

  localparam int IDX_W = $clog2(SB_DEPTH);
  localparam int PTR_W = IDX_W + 1;

  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [ADDR_W-1:0] addr_q [SB_DEPTH];
  logic [DATA_W-1:0] data_q [SB_DEPTH];
  logic              full;
  logic              empty;
  logic              accept;
  logic              drain;

  // Extra pointer MSB separates the full case from the empty case.
  assign empty  = (wr_ptr == rd_ptr);
  assign full   = (wr_ptr[IDX_W-1:0] == rd_ptr[IDX_W-1:0]) &&
                  (wr_ptr[IDX_W] != rd_ptr[IDX_W]);
  assign accept = cmt_wr_en & ~full;
  assign drain  = ~empty & mem_ready;

  // Stall comes only from registered pointers: a full buffer refuses
  // a commit even while it drains, keeping mem_ready off the ROB path.
  assign cmt_stall = full;
  assign mem_req   = ~empty;
  assign mem_addr  = addr_q[rd_ptr[IDX_W-1:0]];
  assign mem_data  = data_q[rd_ptr[IDX_W-1:0]];
  assign sb_empty  = empty;
  assign sb_count  = wr_ptr - rd_ptr;

  // Pointer update: reset discards every held entry.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (accept) wr_ptr <= wr_ptr + 1'b1;
      if (drain)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Entry storage; validity is implied by the pointers, so no reset.
  always_ff @(posedge clk) begin
    if (accept) begin
      addr_q[wr_ptr[IDX_W-1:0]] <= cmt_wr_addr;
      data_q[wr_ptr[IDX_W-1:0]] <= cmt_wr_data;
    end
  end

`ifdef SB_FWD_EN
  logic [PTR_W-1:0] off;
  logic [IDX_W-1:0] idx;

  // Scan oldest to youngest so later matches win; the incoming store wins last.
  always_comb begin
    ld_hit  = 1'b0;
    ld_data = '0;
    off     = '0;
    idx     = '0;
    for (int i = 0; i < SB_DEPTH; i++) begin
      off = PTR_W'(i);
      idx = rd_ptr[IDX_W-1:0] + off[IDX_W-1:0];
      if ((off < sb_count) && (addr_q[idx] == ld_addr)) begin
        ld_hit  = 1'b1;
        ld_data = data_q[idx];
      end
    end
    if (accept && (cmt_wr_addr == ld_addr)) begin
      ld_hit  = 1'b1;
      ld_data = cmt_wr_data;
    end
  end
`else
  // Without forwarding loads must wait for sb_empty; lookup is unused.
  wire unused_ld_addr = &{1'b0, ld_addr};

  assign ld_hit  = 1'b0;
  assign ld_data = '0;
`endif

endmodule
